sha256_pad_1024: RTL and testbench

SHA256_PAD_1024 -- requirements
Module: sha256_pad_1024

---
 rtl/sha256_pad_1024.sv | 116 +++++++++++
 tb/tb_sha256_pad_1024.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_pad_1024.sv
// Collects a byte stream (password + salt) and emits it as a SHA-256 padded
// two-block (1024-bit) message; overlong messages are drained and flagged on err_o.
module sha256_pad_1024 #(
  parameter int MAX_LEN_P = 119
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [1023:0] out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err_o
);

  typedef enum logic [1:0] {COLLECT, OUTPUT, DRAIN} state_e;

  localparam logic [7:0] MaxLen = 8'(MAX_LEN_P);
  localparam logic [7:0] SatLen = 8'(MAX_LEN_P + 1);

  state_e        r_state;
  state_e        w_next;
  logic [1023:0] r_buf;
  logic [7:0]    r_cnt;
  logic          r_err;
  logic          r_live;
  logic          w_take;
  logic          w_fits;
  logic [7:0]    w_cntInc;

  assign w_take   = in_valid && in_ready;
  assign w_fits   = r_cnt < MaxLen;
  assign w_cntInc = r_cnt + 8'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= COLLECT;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      COLLECT: begin
        if (w_take) begin
          if (w_fits) w_next = in_last ? OUTPUT : COLLECT;
          else        w_next = in_last ? COLLECT : DRAIN;
        end
      end
      DRAIN:   if (w_take && in_last) w_next = COLLECT;
      OUTPUT:  if (out_ready) w_next = COLLECT;
      default: w_next = COLLECT;
    endcase
  end

  // r_live keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready  = r_live && (r_state != OUTPUT);
    out_valid = (r_state == OUTPUT);
  end

  assign out   = r_buf;
  assign err_o = r_err;

  // The 0x80 marker and bit count land together with the final byte, so out is
  // complete on the very cycle the FSM enters OUTPUT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_err  <= 1'b0;
      unique case (r_state)
        COLLECT: begin
          if (w_take) begin
            if (w_fits) begin
              r_cnt <= w_cntInc;
              for (int k = 0; k < 120; k++) begin
                if (8'(k) == r_cnt)
                  r_buf[1023-8*k -: 8] <= in_data;
                else if (in_last && (8'(k) == w_cntInc))
                  r_buf[1023-8*k -: 8] <= 8'h80;
              end
              if (in_last) r_buf[63:0] <= {53'd0, w_cntInc, 3'd0};
            end else if (in_last) begin
              r_err <= 1'b1;
              r_cnt <= '0;
              r_buf <= '0;
            end else begin
              r_cnt <= SatLen;
            end
          end
        end
        DRAIN: begin
          if (w_take && in_last) begin
            r_err <= 1'b1;
            r_cnt <= '0;
            r_buf <= '0;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            r_cnt <= '0;
            r_buf <= '0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_pad_1024.sv
// Self-checking bench for sha256_pad_1024: a padding model checks every cycle,
// literal vectors pin the model on known messages.
module tb_sha256_pad_1024;

  localparam int MAX = 119;

  logic          clk_i;
  logic          rst_ni;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  bit randOr   = 1'b0;
  bit manualOr = 1'b0;

  logic [7:0]    msgQ[$];
  logic [1023:0] expData = '0;
  bit            expValid = 1'b0;
  bit            expErr = 1'b0;
  bit            warm = 1'b0;
  int            errSeen = 0;
  int            outDone = 0;

  sha256_pad_1024 #(.MAX_LEN_P(MAX)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_o    (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) begin
    #2;
    out_ready = randOr ? 1'($urandom_range(0, 1)) : manualOr;
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkBlock(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    for (int c = 0; c < 4; c++)
      checkOutput($sformatf("%s[%0d]", name, c), act[c*256 +: 256], exp[c*256 +: 256]);
  endtask

  // Reference padding: message bytes, 0x80, zeros, 64-bit big-endian bit count.
  function automatic logic [1023:0] padMsg(input logic [7:0] m[$]);
    logic [1023:0] r;
    int n;
    r = '0;
    n = m.size();
    for (int i = 0; i < n; i++) r[1023-8*i -: 8] = m[i];
    r[1023-8*n -: 8] = 8'h80;
    r[63:0] = 64'(n) * 64'd8;
    return r;
  endfunction

  // Cycle-level model and compare process, sampled on the falling edge.
  always @(negedge clk_i) begin
    bit take;
    if (!rst_ni) begin
      checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
      checkOutput("rst_err_o", 256'(err_o), 256'(0));
      checkOutput("rst_in_ready", 256'(in_ready), 256'(0));
      checkBlock("rst_out", out, '0);
      msgQ.delete();
      expValid = 1'b0;
      expErr   = 1'b0;
      warm     = 1'b0;
    end else begin
      checkOutput("err_o", 256'(err_o), 256'(expErr));
      checkOutput("out_valid", 256'(out_valid), 256'(expValid));
      checkOutput("in_ready", 256'(in_ready), 256'(warm && !expValid));
      if (expValid) checkBlock("out", out, expData);
      if (err_o) errSeen++;
      take   = warm && !expValid && in_valid;
      expErr = 1'b0;
      if (expValid && out_ready) begin
        expValid = 1'b0;
        outDone++;
      end
      if (take) begin
        msgQ.push_back(in_data);
        if (in_last) begin
          if (msgQ.size() <= MAX) begin
            expData  = padMsg(msgQ);
            expValid = 1'b1;
          end else begin
            expErr = 1'b1;
          end
          msgQ.delete();
        end
      end
      warm = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] m[$], input bit doLast, input int gapPct);
    int waitCnt;
    for (int i = 0; i < m.size(); i++) begin
      if ($urandom_range(0, 99) < gapPct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        in_last  = 1'($urandom_range(0, 1));
        tick();
      end
      in_valid = 1'b1;
      in_data  = m[i];
      in_last  = doLast && (i == m.size() - 1);
      waitCnt  = 0;
      while (!in_ready && waitCnt < 300) begin
        tick();
        waitCnt++;
      end
      if (!in_ready) begin
        total++;
        bad++;
        $display("[TB] FAIL in_ready_timeout actual=0 required=1");
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic releaseOut();
    manualOr = 1'b1;
    tick();
    tick();
    manualOr = 1'b0;
  endtask

  initial begin
    logic [7:0] msg[$];
    int len;
    int longCount;
    int shortCount;
    int errBase;
    int outBase;

    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    rst_ni   = 1'b1;
    #1 rst_ni = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    checkOutput("ready_after_reset", 256'(in_ready), 256'(1));

    // "abc", then hold out_ready low with a byte waiting on the input
    msg = {8'h61, 8'h62, 8'h63};
    applyStimulus(msg, 1'b1, 0);
    checkBlock("abc", out, {32'h61626380, 928'd0, 64'h18});
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_in_ready", 256'(in_ready), 256'(0));
    end
    checkBlock("hold_out", out, {32'h61626380, 928'd0, 64'h18});
    manualOr = 1'b1;
    tick();
    tick();
    manualOr = 1'b0;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkBlock("after_hold", out, {16'h5580, 944'd0, 64'h8});
    releaseOut();

    // maximum length message
    msg.delete();
    for (int i = 0; i < 119; i++) msg.push_back(8'hAA);
    applyStimulus(msg, 1'b1, 0);
    checkBlock("max_len", out, {{119{8'hAA}}, 8'h80, 64'h3B8});
    releaseOut();

    // overflow on the last byte, then abc again
    msg.push_back(8'hAA);
    applyStimulus(msg, 1'b1, 0);
    checkOutput("ovf120_err", 256'(err_o), 256'(1));
    tick();
    checkOutput("ovf120_err_low", 256'(err_o), 256'(0));
    checkOutput("ovf120_no_valid", 256'(out_valid), 256'(0));
    msg = {8'h61, 8'h62, 8'h63};
    applyStimulus(msg, 1'b1, 0);
    checkBlock("abc_after_ovf", out, {32'h61626380, 928'd0, 64'h18});
    releaseOut();

    // overflow that goes through the drain phase
    msg.delete();
    for (int i = 0; i < 123; i++) msg.push_back(8'(i));
    applyStimulus(msg, 1'b1, 0);
    checkOutput("drain_err", 256'(err_o), 256'(1));
    tick();
    checkOutput("drain_err_low", 256'(err_o), 256'(0));

    // reset in the middle of a message
    msg = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    applyStimulus(msg, 1'b0, 0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    msg = {8'h41};
    applyStimulus(msg, 1'b1, 0);
    checkBlock("after_reset", out, {16'h4180, 944'd0, 64'h8});
    releaseOut();

    // random lengths with random input and output gaps
    longCount  = 0;
    shortCount = 0;
    errBase    = errSeen;
    outBase    = outDone;
    randOr     = 1'b1;
    for (int m = 0; m < 200; m++) begin
      len = $urandom_range(1, 125);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      if (len > MAX) longCount++;
      else shortCount++;
      applyStimulus(msg, 1'b1, 25);
    end
    randOr   = 1'b0;
    manualOr = 1'b1;
    repeat (20) tick();
    checkOutput("rand_err_count", 256'(errSeen - errBase), 256'(longCount));
    checkOutput("rand_out_count", 256'(outDone - outBase), 256'(shortCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
